// File: rtl/cell_position_tagger_pkg.sv
// rtl/cell_position_tagger_pkg.sv - shared state encoding and cell geometry
package cell_position_tagger_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int CELL_W = 6;
    localparam int CELL_H = 6;

endpackage

// File: rtl/cell_position_tagger_divide.sv
// rtl/cell_position_tagger_divide.sv - combinational divide-by-6 of a 7-bit coordinate
module N_divide_6 (
    input  logic [6:0] iN,
    output logic [4:0] oResult,
    output logic [2:0] oRemain
);

    // 127/6 = 21 fits in 5 bits and the remainder is at most 5
    assign oResult = 5'(iN / 7'd6);
    assign oRemain = 3'(iN % 7'd6);

endmodule

// File: rtl/cell_position_tagger.sv
// rtl/cell_position_tagger.sv - tags each pixel beat with its 6x6 cell and in-cell position
module cell_position_tagger
    import cell_position_tagger_pkg::*;
#(
    parameter int DW           = 24,
    parameter int LINE_WIDTH   = 120,
    parameter int FRAME_HEIGHT = 90
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] stream_in_data,
    input  logic          stream_in_startofpacket,
    input  logic          stream_in_endofpacket,
    input  logic          stream_in_valid,
    output logic          stream_in_ready,
    output logic [DW-1:0] stream_out_data,
    output logic          stream_out_startofpacket,
    output logic          stream_out_endofpacket,
    output logic          stream_out_valid,
    input  logic          stream_out_ready,
    output logic [4:0]    stream_out_cell_col,
    output logic [2:0]    stream_out_px_col,
    output logic [4:0]    stream_out_cell_row,
    output logic [2:0]    stream_out_px_row,
    output logic          frame_error
);

    localparam logic [6:0] X_LAST = 7'(LINE_WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(FRAME_HEIGHT - 1);

    state_e        state_q, state_d;
    logic [6:0]    x_q, x_d, y_q, y_d;
    logic [6:0]    tag_x, tag_y;
    logic          fwd, err_d, accept;
    logic [4:0]    cell_col_d, cell_row_d;
    logic [2:0]    px_col_d, px_row_d;

    logic [DW-1:0] data_q;
    logic          sop_q, eop_q, valid_q, valid_d, err_q;
    logic [4:0]    cell_col_q, cell_row_q;
    logic [2:0]    px_col_q, px_row_q;

    // Held low in reset so nothing is accepted before the output stage is live
    assign stream_in_ready = reset_n & (stream_out_ready | ~valid_q);
    assign accept          = stream_in_valid & stream_in_ready;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tag_x   = x_q;
        tag_y   = y_q;
        fwd     = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            if (stream_in_startofpacket) begin
                fwd   = 1'b1;
                tag_x = '0;
                tag_y = '0;
                if (stream_in_endofpacket) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    err_d   = (state_q == ACTIVE) && ((x_q != '0) || (y_q != '0));
                    state_d = ACTIVE;
                    x_d     = 7'd1;
                    y_d     = '0;
                end
            end else if (state_q == ACTIVE) begin
                fwd = 1'b1;
                if (stream_in_endofpacket) begin
                    err_d   = !((x_q == X_LAST) && (y_q == Y_LAST));
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d   = '0;
                        err_d = 1'b1;
                    end else begin
                        y_d = y_q + 7'd1;
                    end
                end else begin
                    x_d = x_q + 7'd1;
                end
            end
        end
    end

    assign valid_d = fwd | (valid_q & ~stream_out_ready);

    N_divide_6 u_div_x (
        .iN      (tag_x),
        .oResult (cell_col_d),
        .oRemain (px_col_d)
    );

    N_divide_6 u_div_y (
        .iN      (tag_y),
        .oResult (cell_row_d),
        .oRemain (px_row_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            data_q     <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cell_col_q <= '0;
            px_col_q   <= '0;
            cell_row_q <= '0;
            px_row_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (fwd) begin
                data_q     <= stream_in_data;
                sop_q      <= stream_in_startofpacket;
                eop_q      <= stream_in_endofpacket;
                cell_col_q <= cell_col_d;
                px_col_q   <= px_col_d;
                cell_row_q <= cell_row_d;
                px_row_q   <= px_row_d;
            end
        end
    end

    assign stream_out_data          = data_q;
    assign stream_out_startofpacket = sop_q;
    assign stream_out_endofpacket   = eop_q;
    assign stream_out_valid         = valid_q;
    assign stream_out_cell_col      = cell_col_q;
    assign stream_out_px_col        = px_col_q;
    assign stream_out_cell_row      = cell_row_q;
    assign stream_out_px_row        = px_row_q;
    assign frame_error              = err_q;

endmodule

// File: tb/tb_cell_position_tagger.sv
// tb/tb_cell_position_tagger.sv - self-checking bench for cell_position_tagger
module tb_cell_position_tagger;

    localparam int DW   = 24;
    localparam int LW   = 120;
    localparam int FH   = 90;
    localparam int NPIX = LW * FH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_sop, in_eop, in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_sop, out_eop, out_valid, out_ready;
    logic [4:0]    cell_col, cell_row;
    logic [2:0]    px_col, px_row;
    logic          frame_error;

    cell_position_tagger #(.DW(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .stream_in_data           (in_data),
        .stream_in_startofpacket  (in_sop),
        .stream_in_endofpacket    (in_eop),
        .stream_in_valid          (in_valid),
        .stream_in_ready          (in_ready),
        .stream_out_data          (out_data),
        .stream_out_startofpacket (out_sop),
        .stream_out_endofpacket   (out_eop),
        .stream_out_valid         (out_valid),
        .stream_out_ready         (out_ready),
        .stream_out_cell_col      (cell_col),
        .stream_out_px_col        (px_col),
        .stream_out_cell_row      (cell_row),
        .stream_out_px_row        (px_row),
        .frame_error              (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop, eop;
        int            cc, pc, cr, pr;
    } beat_t;

    typedef struct {
        int idx;
        int cc, pc, cr, pr;
    } vec_t;

    beat_t exp_q[$];
    beat_t out_log[$];
    vec_t  vt[9];
    int    checks   = 0;
    int    failures = 0;
    int    err_pulses = 0;
    bit    m_active = 0;
    int    m_idx    = 0;
    bit    exp_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input beat_t b);
        return {22'd0, b.data, b.sop, b.eop, 5'(b.cc), 3'(b.pc), 5'(b.cr), 3'(b.pr)};
    endfunction

    // Frame position is a linear beat index; x,y and the cell split fall out of it
    task automatic model_accept(input bit s, input bit e, input logic [DW-1:0] d);
        beat_t b;
        int    p = 0;
        bit    f = 0;
        bit    er = 0;
        if (s) begin
            f  = 1;
            p  = 0;
            er = e ? 1'b1 : (m_active && (m_idx % NPIX != 0));
            m_active = !e;
            m_idx    = e ? 0 : 1;
        end else if (m_active) begin
            f = 1;
            p = m_idx % NPIX;
            if (e) begin
                er       = (p != NPIX - 1);
                m_active = 0;
                m_idx    = 0;
            end else begin
                er = (p == NPIX - 1);
                m_idx++;
            end
        end
        if (f) begin
            b.data = d;
            b.sop  = s;
            b.eop  = e;
            b.cc   = (p % LW) / 6;
            b.pc   = (p % LW) % 6;
            b.cr   = (p / LW) / 6;
            b.pr   = (p / LW) % 6;
            exp_q.push_back(b);
        end
        exp_err = er;
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input logic [DW-1:0] d, input bit rdy);
        beat_t a, x;
        @(negedge clk);
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = d;
        out_ready = rdy;
        #1;
        check("frame_error", frame_error, exp_err);
        if (frame_error) err_pulses++;
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, rdy || exp_q.size() == 0);
        if (out_valid && rdy) begin
            a.data = out_data; a.sop = out_sop; a.eop = out_eop;
            a.cc = cell_col; a.pc = px_col; a.cr = cell_row; a.pr = px_row;
            out_log.push_back(a);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("beat", pack(a), pack(x));
            end
        end
        exp_err = 0;
        if (v && in_ready) model_accept(s, e, d);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 0;
        m_idx    = 0;
        exp_err  = 0;
    endtask

    initial begin
        int e0;
        vt[0] = '{0,     0,  0, 0,  0};
        vt[1] = '{6,     1,  0, 0,  0};
        vt[2] = '{37,    6,  1, 0,  0};
        vt[3] = '{119,   19, 5, 0,  0};
        vt[4] = '{120,   0,  0, 0,  1};
        vt[5] = '{725,   0,  5, 1,  0};
        vt[6] = '{845,   0,  5, 1,  1};
        vt[7] = '{5000,  13, 2, 6,  5};
        vt[8] = '{10799, 19, 5, 14, 5};

        reset_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; out_ready = 0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_data", out_data, 0);
        check("rst_tags", {cell_col, px_col, cell_row, px_row, out_sop, out_eop}, 0);
        out_ready = 1;
        #1;
        check("rst_in_ready_rdy", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // One full clean frame with occasional upstream gaps
        out_log.delete();
        e0 = err_pulses;
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(0, 7) == 0) drive(0, 0, 0, '0, 1);
            drive(1, i == 0, i == NPIX - 1, DW'($urandom), 1);
        end
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 1);
        check("frame_beats", out_log.size(), NPIX);
        check("frame_err_count", err_pulses - e0, 0);
        for (int t = 0; t < 9; t++) begin
            if (vt[t].idx < out_log.size()) begin
                beat_t b;
                b = out_log[vt[t].idx];
                check($sformatf("tag_idx%0d", vt[t].idx),
                      {b.cc[7:0], b.pc[7:0], b.cr[7:0], b.pr[7:0]},
                      {vt[t].cc[7:0], vt[t].pc[7:0], vt[t].cr[7:0], vt[t].pr[7:0]});
            end
        end

        // Non-sop beats in IDLE are dropped, then a short frame ends early at x=10,y=3
        for (int i = 0; i < 3; i++) drive(1, 0, 0, DW'($urandom), 1);
        drive(1, 1, 0, 24'h00abcd, 1);
        drive(1, 0, 0, DW'($urandom), 1);
        check("sop_after_drop", {out_sop, out_data, cell_col, px_col, cell_row, px_row},
              {1'b1, 24'h00abcd, 16'd0});
        e0 = err_pulses;
        for (int i = 2; i <= 370; i++) drive(1, 0, i == 370, DW'($urandom), 1);
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 1);
        check("early_eop_pulses", err_pulses - e0, 1);

        // Mid-frame sop at x=50,y=2
        drive(1, 1, 0, DW'($urandom), 1);
        for (int i = 1; i < 290; i++) drive(1, 0, 0, DW'($urandom), 1);
        drive(1, 1, 0, 24'h0055aa, 1);
        drive(1, 0, 0, DW'($urandom), 1);
        check("mid_sop_tag", {out_sop, out_data, cell_col, px_col, cell_row, px_row},
              {1'b1, 24'h0055aa, 16'd0});
        check("mid_sop_err", frame_error, 1);

        // Downstream stall while x=37 is on the output
        for (int i = 2; i <= 37; i++) drive(1, 0, 0, DW'($urandom), 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, DW'($urandom), 0);
            check("stall_tag", {cell_col, px_col}, {5'd6, 3'd1});
            check("stall_in_ready", in_ready, 0);
        end
        for (int i = 0; i < 6; i++) drive(1, 0, 0, DW'($urandom), 1);

        // Async reset while a beat is held
        drive(0, 0, 0, '0, 0);
        check("held_valid", out_valid, 1);
        #1 reset_n = 0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        in_valid = 0;
        reset_n  = 1;
        drive(1, 0, 0, DW'($urandom), 1);
        drive(0, 0, 0, '0, 1);
        check("post_rst_drop", out_valid, 0);

        // Random traffic with random backpressure and framing
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 59) == 0, DW'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, '0, 1);
        check("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cell_position_tagger.md
CELL_POSITION_TAGGER -- requirements
Module: cell_position_tagger

Interface
REQ-001 Parameter DW, default 24: pixel data width in bits.
REQ-002 Parameter LINE_WIDTH, default 120: pixels per line, range 6..128.
REQ-003 Parameter FRAME_HEIGHT, default 90: lines per frame, range 6..128.
REQ-004 Port clk, input, 1: the single clock; all state is clocked on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports stream_in_data (DW), stream_in_startofpacket (1), stream_in_endofpacket (1), stream_in_valid (1), all inputs: upstream pixel beat.
REQ-007 Port stream_in_ready, output, 1: upstream backpressure.
REQ-008 Ports stream_out_data (DW), stream_out_startofpacket (1), stream_out_endofpacket (1), stream_out_valid (1), all outputs: forwarded beat.
REQ-009 Port stream_out_ready, input, 1: downstream backpressure.
REQ-010 Ports stream_out_cell_col (5), stream_out_px_col (3), stream_out_cell_row (5), stream_out_px_row (3), all outputs: x/6 quotient, x mod 6, y/6 quotient, y mod 6 of the forwarded beat.
REQ-011 Port frame_error, output, 1: one-cycle pulse on a malformed frame.

Function
REQ-012 A beat transfers in when stream_in_valid and stream_in_ready are both high; it transfers out when stream_out_valid and stream_out_ready are both high.
REQ-013 stream_in_ready SHALL equal stream_out_ready OR NOT stream_out_valid (single-stage output register).
REQ-014 The block SHALL have two states, IDLE and ACTIVE; reset enters IDLE.
REQ-015 IDLE: beats without startofpacket are accepted and dropped (not forwarded); a beat with startofpacket is forwarded with x=0, y=0, and the state moves to ACTIVE.
REQ-016 ACTIVE: each accepted beat is forwarded tagged with the current x,y; then x increments, and at x=LINE_WIDTH-1 x wraps to 0 and y increments.
REQ-017 ACTIVE, beat carrying endofpacket: forwarded, counters cleared to 0, state returns to IDLE; frame_error pulses unless x=LINE_WIDTH-1 and y=FRAME_HEIGHT-1.
REQ-018 ACTIVE, beat carrying startofpacket: forwarded as the first beat of a new frame with x=0, y=0; frame_error pulses if the current x,y were not 0,0; state stays ACTIVE.
REQ-019 ACTIVE, y would exceed FRAME_HEIGHT-1 without endofpacket: y wraps to 0 and frame_error pulses.
REQ-020 A beat with both startofpacket and endofpacket is forwarded at x=0, y=0 and leaves the block in IDLE; frame_error pulses unless LINE_WIDTH=FRAME_HEIGHT=1 (never, given REQ-002 and REQ-003).
REQ-021 Quotient and remainder are computed combinationally from the 7-bit x and y, then registered together with the data: latency is exactly one cycle from input transfer to stream_out_valid.
REQ-022 Output registers SHALL hold their values while stream_out_valid=1 and stream_out_ready=0.

Reset
REQ-023 While reset_n=0, all outputs SHALL be 0 except stream_in_ready, which is 0 during reset and follows REQ-013 after release.
REQ-024 While reset_n=0, x and y SHALL be 0 and the state IDLE.
REQ-025 A reset mid-frame discards any held output beat; the first beat after release must carry startofpacket to be forwarded.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=0, ACTIVE=1) and the constants CELL_W=6 and CELL_H=6.
REQ-027 The divider SHALL be two instances of the existing combinational sub-module N_divide_6 (iN[6:0] to oResult[4:0], oRemain[2:0]), one for x and one for y.

Verification
REQ-028 Scenario: reset, then one full 120x90 frame with stream_out_ready=1.
- Expected: the 7th beat is tagged cell_col=1, px_col=0; the last beat is tagged cell_col=19, px_col=5, cell_row=14, px_row=5; frame_error stays 0.
REQ-029 Scenario: three non-sop beats, then a sop beat.
- Expected: the first three beats are dropped and nothing appears on the output; the sop beat appears one cycle later tagged 0/0/0/0.
REQ-030 Scenario: stream_out_ready=0 for 5 cycles mid-line at x=37.
- Expected: the output holds cell_col=6, px_col=1; stream_in_ready=0; no beat is lost or duplicated.
REQ-031 Scenario: endofpacket arrives at x=10, y=3.
- Expected: frame_error pulses for exactly 1 cycle; the next sop beat is tagged 0/0/0/0.
REQ-032 Scenario: reset_n is pulsed low while stream_out_valid=1.
- Expected: stream_out_valid goes to 0 immediately, without waiting for a clock edge; a beat without sop after release is dropped.
REQ-033 Scenario: a sop arrives mid-frame at x=50, y=2.
- Expected: frame_error pulses; the beat is tagged 0/0/0/0.
